// File: rtl/mem_stage_unit_pkg.sv
// Shared types for the MEM stage: FSM state and the MEM/WB register bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic            regwrite;
        logic            memtoreg;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_data;
        logic [4:0]      rd;
    } memwb_t;

    // A bubble carries no register write and no data.
    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_unit_wait_timer.sv
// Counts cycles spent waiting for a memory ack; flags the final allowed cycle.
// Latency: timeout_o is combinational from the registered count.
// Backpressure: none; start/clear zero the count, tick advances it.
module mem_wait_timer #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic timeout_o
);

    localparam int CW = 8;

    logic [CW-1:0] count;

    // Count restarts on each issue and on completion; ticks once per unacked wait cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (start_i || clear_i) begin
            count <= '0;
        end else if (tick_i) begin
            count <= count + 8'd1;
        end
    end

    assign timeout_o = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: resolves branches, runs loads/stores over req/ack, writes MEM/WB.
// Latency: 1 cycle for non-memory ops; memory ops take issue + ack cycles (min 2).
// Backpressure: stall_o holds upstream while an access is in flight or being issued.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] ALUResult_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic            Zero_i,
    input  logic [XLEN-1:0] pc_branch_i,
    input  logic            Branch_i,
    input  logic            MemRead_i,
    input  logic            MemtoReg_i,
    input  logic            MemWrite_i,
    input  logic            RegWrite_i,
    input  logic [4:0]      RDaddr_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            stall_o,
    output logic            PCSrc_o,
    output logic [XLEN-1:0] pc_branch_o,
    output logic            RegWrite_o,
    output logic            MemtoReg_o,
    output logic [XLEN-1:0] ALUResult_o,
    output logic [XLEN-1:0] MemData_o,
    output logic [4:0]      RDaddr_o,
    output logic            mem_err_o
);

    state_t          state, state_nxt;
    memwb_t          memwb, memwb_nxt;
    logic            access;
    logic            timeout_raw;
    logic            timeout;
    logic            req_nxt;
    logic            we_nxt;
    logic [XLEN-1:0] addr_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic            err_nxt;
    logic            tmr_start;
    logic            tmr_clear;
    logic            tmr_tick;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (tmr_start),
        .clear_i   (tmr_clear),
        .tick_i    (tmr_tick),
        .timeout_o (timeout_raw)
    );

    assign access      = MemRead_i | MemWrite_i;
    assign timeout     = (state == WAIT) & timeout_raw;
    assign PCSrc_o     = Branch_i & Zero_i;
    assign pc_branch_o = pc_branch_i;
    // Reset drops any in-flight access at once, so the stall must drop with it
    // even though EX/MEM may still be presenting a memory op.
    assign stall_o     = ~rst_i & (((state == IDLE) & access) |
                                   ((state == WAIT) & ~mem_ack_i & ~timeout));

    assign RegWrite_o  = memwb.regwrite;
    assign MemtoReg_o  = memwb.memtoreg;
    assign ALUResult_o = memwb.alu_result;
    assign MemData_o   = memwb.mem_data;
    assign RDaddr_o    = memwb.rd;

    // State, memory request and MEM/WB registers; everything clears asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            memwb       <= MEMWB_BUBBLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            memwb       <= memwb_nxt;
            mem_req_o   <= req_nxt;
            mem_we_o    <= we_nxt;
            mem_addr_o  <= addr_nxt;
            mem_wdata_o <= wdata_nxt;
            mem_err_o   <= err_nxt;
        end
    end

    // Next-state: issue from IDLE, complete or abort from WAIT; ack beats timeout.
    always_comb begin
        state_nxt = state;
        memwb_nxt = memwb;
        req_nxt   = mem_req_o;
        we_nxt    = mem_we_o;
        addr_nxt  = mem_addr_o;
        wdata_nxt = mem_wdata_o;
        err_nxt   = mem_err_o;
        tmr_start = 1'b0;
        tmr_clear = 1'b0;
        tmr_tick  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    addr_nxt  = ALUResult_i;
                    wdata_nxt = MemRead_i ? '0 : RS2data_i;
                    we_nxt    = MemWrite_i & ~MemRead_i;
                    req_nxt   = 1'b1;
                    tmr_start = 1'b1;
                    memwb_nxt = MEMWB_BUBBLE;
                    state_nxt = WAIT;
                end else begin
                    memwb_nxt.regwrite   = RegWrite_i;
                    memwb_nxt.memtoreg   = MemtoReg_i;
                    memwb_nxt.alu_result = ALUResult_i;
                    memwb_nxt.mem_data   = '0;
                    memwb_nxt.rd         = RDaddr_i;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    memwb_nxt.regwrite   = RegWrite_i;
                    memwb_nxt.memtoreg   = MemtoReg_i;
                    memwb_nxt.alu_result = ALUResult_i;
                    memwb_nxt.mem_data   = mem_we_o ? '0 : mem_rdata_i;
                    memwb_nxt.rd         = RDaddr_i;
                    req_nxt              = 1'b0;
                    tmr_clear            = 1'b1;
                    state_nxt            = IDLE;
                end else if (timeout) begin
                    memwb_nxt = MEMWB_BUBBLE;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    tmr_clear = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_tick = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
